// File: rtl/uart_rx_fifo.sv
// UART receiver with a configurable frame format, majority-vote sampling
// and a receive FIFO carrying per-character error flags.
module uart_rx_fifo #(
   parameter int CLK_FRQ   = 0,
   parameter int BAUD_RATE = 0,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW   = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_brk,
   output logic                 rx_data_ready,
   input  logic                 rx_pop,
   output logic [FIFO_AW:0]     rx_count,
   output logic                 rx_overrun,
   input  logic                 err_clear,
   output logic                 rx_busy
);

   localparam int CYCLE = CLK_FRQ / ((BAUD_RATE > 0) ? BAUD_RATE : 1);
   localparam logic [15:0] C_LAST = 16'(CYCLE - 1);
   localparam logic [15:0] C_V1   = 16'(CYCLE / 2 - 1);
   localparam logic [15:0] C_V2   = 16'(CYCLE / 2);
   localparam logic [15:0] C_RES  = 16'(CYCLE / 2 + 1);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int EW    = DATA_BITS + 3;

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
   } state_t;

   state_t               state, state_nxt;
   logic                 s0, s1;
   logic [15:0]          cnt, cnt_nxt;
   logic [2:0]           idx, idx_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic                 v1, v2, maj, samp, bit_last;
   logic                 perr, perr_nxt;
   logic                 ferr, ferr_nxt;
   logic                 zero, zero_nxt;
   logic                 stp2, stp2_nxt;
   logic                 push, brk_v, ferr_v;
   logic [EW-1:0]        entry;

   assign maj      = (v1 & v2) | (v1 & s0) | (v2 & s0);
   assign samp     = (cnt == C_RES);
   assign bit_last = (cnt == C_LAST);
   // zero tracks "every bit so far was 0"; after the first stop it is the break flag
   assign brk_v    = stp2 ? zero : (zero & ~maj);
   assign ferr_v   = ferr | ~maj;
   assign entry    = {brk_v, ferr_v, perr, shift};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_last ? 16'd0 : cnt + 16'd1;
      idx_nxt   = idx;
      shift_nxt = shift;
      perr_nxt  = perr;
      ferr_nxt  = ferr;
      zero_nxt  = zero;
      stp2_nxt  = stp2;
      push      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_nxt = 16'd0;
            if (s1 && !s0) begin
               state_nxt = ST_START;
               perr_nxt  = 1'b0;
               ferr_nxt  = 1'b0;
               zero_nxt  = 1'b1;
               stp2_nxt  = 1'b0;
            end
         end
         ST_START: begin
            if (samp && maj) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = 16'd0;
            end else if (bit_last) begin
               state_nxt = ST_DATA;
               idx_nxt   = 3'd0;
            end
         end
         ST_DATA: begin
            if (samp) begin
               shift_nxt = {maj, shift[DATA_BITS-1:1]};
               zero_nxt  = zero & ~maj;
            end
            if (bit_last) begin
               idx_nxt = idx + 3'd1;
               if (idx == 3'(DATA_BITS - 1))
                  state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (samp) begin
               perr_nxt = (^shift) ^ maj ^ (PARITY == 1);
               zero_nxt = zero & ~maj;
            end
            if (bit_last)
               state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (samp) begin
               ferr_nxt = ferr_v;
               if (STOP_BITS == 2 && !stp2) begin
                  zero_nxt = brk_v;
               end else begin
                  push      = 1'b1;
                  state_nxt = ST_IDLE;
                  cnt_nxt   = 16'd0;
               end
            end
            if (bit_last)
               stp2_nxt = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0    <= 1'b1;
         s1    <= 1'b1;
         state <= ST_IDLE;
         cnt   <= 16'd0;
         idx   <= 3'd0;
         shift <= '0;
         v1    <= 1'b1;
         v2    <= 1'b1;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         zero  <= 1'b0;
         stp2  <= 1'b0;
      end else begin
         s0    <= rx_in;
         s1    <= s0;
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
         if (cnt == C_V1) v1 <= s0;
         if (cnt == C_V2) v2 <= s0;
         perr  <= perr_nxt;
         ferr  <= ferr_nxt;
         zero  <= zero_nxt;
         stp2  <= stp2_nxt;
      end
   end

   logic [EW-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               full, do_pop, do_wr, ovf;
   logic [EW-1:0]      head;

   assign full   = (count == (FIFO_AW + 1)'(DEPTH));
   assign do_pop = rx_pop && (count != '0);
   // a pop in the same cycle frees the slot the push needs
   assign do_wr  = push && (!full || do_pop);
   assign ovf    = push && full && !do_pop;

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_wr, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf)
            rx_overrun <= 1'b1;
         else if (err_clear)
            rx_overrun <= 1'b0;
      end
   end

   assign head          = mem[rd_ptr];
   assign rx_data_ready = (count != '0);
   assign rx_count      = count;
   assign rx_busy       = (state != ST_IDLE);
   assign {rx_brk, rx_ferr, rx_perr, rx_data} = rx_data_ready ? head : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: 8N1 receiver with a 4-deep FIFO and a 7E2 receiver.
module tb_uart_rx_fifo;

   localparam int CYC = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic       rx_a = 1'b1, pop_a = 1'b0, clr_a = 1'b0;
   logic [7:0] a_data;
   logic       a_perr, a_ferr, a_brk, a_ready, a_ovr, a_busy;
   logic [2:0] a_count;

   logic       rx_b = 1'b1, pop_b = 1'b0, clr_b = 1'b0;
   logic [6:0] b_data;
   logic       b_perr, b_ferr, b_brk, b_ready, b_ovr, b_busy;
   logic [4:0] b_count;

   uart_rx_fifo #(
      .CLK_FRQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .rx_in(rx_a),
      .rx_data(a_data), .rx_perr(a_perr), .rx_ferr(a_ferr),
      .rx_brk(a_brk), .rx_data_ready(a_ready), .rx_pop(pop_a),
      .rx_count(a_count), .rx_overrun(a_ovr), .err_clear(clr_a),
      .rx_busy(a_busy)
   );

   uart_rx_fifo #(
      .CLK_FRQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7),
      .PARITY(2), .STOP_BITS(2), .FIFO_AW(4)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .rx_in(rx_b),
      .rx_data(b_data), .rx_perr(b_perr), .rx_ferr(b_ferr),
      .rx_brk(b_brk), .rx_data_ready(b_ready), .rx_pop(pop_b),
      .rx_count(b_count), .rx_overrun(b_ovr), .err_clear(clr_b),
      .rx_busy(b_busy)
   );

   int n_chk = 0;
   int n_fail = 0;
   logic [10:0] qa[$];
   logic [10:0] qb[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] head(input int sel);
      return (sel == 0) ? {a_brk, a_ferr, a_perr, a_data}
                        : {b_brk, b_ferr, b_perr, 1'b0, b_data};
   endfunction

   function automatic logic rdy(input int sel);
      return (sel == 0) ? a_ready : b_ready;
   endfunction

   function automatic logic [10:0] model_b(input logic [6:0] d,
      input logic par, input logic st1, input logic st2);
      logic brk;
      brk = (d == 7'd0) && !par && !st1;
      return {brk, !st1 || !st2, (^d) ^ par, 1'b0, d};
   endfunction

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) rx_a = v;
      else rx_b = v;
   endtask

   task automatic send_bits(input int sel, input logic [15:0] bits,
                            input int n);
      for (int i = 0; i < n; i++) begin
         set_rx(sel, bits[i]);
         repeat (CYC) @(posedge clk);
         #1;
      end
      set_rx(sel, 1'b1);
   endtask

   task automatic send_a(input logic [7:0] d, input bit expect_it);
      if (expect_it) qa.push_back({3'b000, d});
      send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10);
      repeat (CYC) @(posedge clk);
      #1;
   endtask

   task automatic send_b(input logic [6:0] d, input logic par,
                         input logic st1, input logic st2);
      qb.push_back(model_b(d, par, st1, st2));
      send_bits(1, {5'b0, st2, st1, par, d, 1'b0}, 11);
      repeat (CYC) @(posedge clk);
      #1;
   endtask

   task automatic pulse_pop(input int sel);
      @(posedge clk);
      #1;
      if (sel == 0) pop_a = 1'b1;
      else pop_b = 1'b1;
      @(posedge clk);
      #1;
      pop_a = 1'b0;
      pop_b = 1'b0;
   endtask

   task automatic drain(input int sel, input int n);
      logic [10:0] exp;
      int t;
      for (int k = 0; k < n; k++) begin
         if (sel == 0 && qa.size() == 0) break;
         if (sel == 1 && qb.size() == 0) break;
         t = 0;
         @(negedge clk);
         while (!rdy(sel) && t < 500) begin
            @(negedge clk);
            t++;
         end
         chk("ready_wait", rdy(sel), 1);
         exp = (sel == 0) ? qa.pop_front() : qb.pop_front();
         chk("head_entry", head(sel), exp);
         pulse_pop(sel);
      end
      @(negedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", a_ready, 0);
      chk("rst_count", a_count, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_ovr", a_ovr, 0);
      chk("rst_head", head(0), 0);
      chk("rst_b_ready", b_ready, 0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      send_a(8'hA5, 1);
      @(negedge clk);
      chk("a5_ready", a_ready, 1);
      chk("a5_count", a_count, 1);
      drain(0, 99);
      chk("a5_count_after", a_count, 0);
      chk("a5_ready_after", a_ready, 0);

      busy = 0;
      @(posedge clk);
      #1;
      fork
         begin
            rx_a = 1'b0;
            repeat (4) @(posedge clk);
            #1 rx_a = 1'b1;
         end
         begin
            repeat (40) begin
               @(negedge clk);
               if (a_busy) busy++;
            end
         end
      join
      chk("glitch_busy_seen", busy > 0, 1);
      chk("glitch_busy_max", busy <= CYC / 2 + 2, 1);
      chk("glitch_count", a_count, 0);

      for (int i = 1; i <= 5; i++)
         send_a(8'(i), i <= 4);
      @(negedge clk);
      chk("ovr_count", a_count, 4);
      chk("ovr_flag", a_ovr, 1);
      drain(0, 99);
      chk("ovr_sticky", a_ovr, 1);
      @(posedge clk);
      #1 clr_a = 1'b1;
      @(posedge clk);
      #1 clr_a = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", a_ovr, 0);

      for (int i = 8'h11; i <= 8'h14; i++)
         send_a(8'(i), 1);
      qa.push_back(11'h015);
      @(posedge clk);
      #1;
      fork
         send_bits(0, {6'b0, 1'b1, 8'h15, 1'b0}, 10);
         begin
            repeat (155) @(posedge clk);
            #1;
            chk("push_pop_head", head(0), qa.pop_front());
            pop_a = 1'b1;
            @(posedge clk);
            #1 pop_a = 1'b0;
         end
      join
      @(negedge clk);
      chk("push_pop_count", a_count, 4);
      chk("push_pop_ovr", a_ovr, 0);
      drain(0, 2);
      chk("partial_count", a_count, 2);

      @(posedge clk);
      #1 rx_a = 1'b0;
      repeat (40) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_count", a_count, 0);
      chk("mid_rst_ready", a_ready, 0);
      chk("mid_rst_head", head(0), 0);
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_ovr", a_ovr, 0);
      qa.delete();
      rx_a = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2 * CYC) @(posedge clk);
      #1;
      send_a(8'h5A, 1);
      drain(0, 99);
      chk("post_rst_count", a_count, 0);

      send_b(7'h41, 1'b0, 1'b1, 1'b1);
      send_b(7'h41, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("par_count", b_count, 2);
      drain(1, 99);
      send_b(7'h3C, 1'b0, 1'b1, 1'b0);
      drain(1, 99);

      qb.push_back(model_b(7'h00, 1'b0, 1'b0, 1'b0));
      rx_b = 1'b0;
      repeat (12 * CYC) @(posedge clk);
      #1 rx_b = 1'b1;
      repeat (3 * CYC) @(posedge clk);
      @(negedge clk);
      chk("brk_count", b_count, 1);
      drain(1, 99);
      @(posedge clk);
      #1;
      send_b(7'h2B, ^7'h2B, 1'b1, 1'b1);
      drain(1, 99);
      chk("b_final_count", b_count, 0);
      chk("b_ovr", b_ovr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the console UART receiver.
- Configurable frame format: data bits, parity, stop bits.
- Majority-vote mid-bit sampling; per-character framing, parity and break detection; receive FIFO with sticky overrun flag.
- Sits between the board RX pin and the CPU-side serial register interface; replaces the single-byte rx_data/rx_clear holding register.

Parameters:
- CLK_FRQ, 0, clock frequency in Hz; must be set by the instantiator.
- BAUD_RATE, 0, serial baud rate; CYCLE = CLK_FRQ/BAUD_RATE, legal range 8..65535.
- DATA_BITS, 8, data bits per character, legal 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active low
- rx_in  in  1  serial input, idle high, asynchronous to clk
- rx_data  out  DATA_BITS  character at FIFO head
- rx_perr  out  1  parity error flag of head entry
- rx_ferr  out  1  framing error flag of head entry
- rx_brk  out  1  break flag of head entry
- rx_data_ready  out  1  FIFO not empty
- rx_pop  in  1  one-cycle pulse; removes head entry
- rx_count  out  FIFO_AW+1  entries held, 0..2**FIFO_AW
- rx_overrun  out  1  sticky: a character was dropped because the FIFO was full
- err_clear  in  1  one-cycle pulse; clears rx_overrun
- rx_busy  out  1  receiver frame in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; all counters 0; FIFO empty.
  - Outputs 0: rx_data, rx_perr, rx_ferr, rx_brk, rx_data_ready, rx_count, rx_overrun, rx_busy.
  - Both input synchroniser flops reset to 1, so no false start edge occurs on reset release.
- Input: rx_in passes through a 2-flop synchroniser (s0, s1). Start edge = s1 high and s0 low.
- Bit timing: 16-bit cnt runs 0..CYCLE-1 per bit period. Sample value = majority of s0 at cnt = CYCLE/2-1, CYCLE/2, CYCLE/2+1; it is resolved at cnt = CYCLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on start edge -> START, cnt = 0.
  - START: if the resolved sample is 1, false start -> IDLE with no push. Otherwise, at cnt = CYCLE-1 -> DATA, cnt = 0, bit index = 0.
  - DATA: resolved sample written to shift[bit index], LSB first. At cnt = CYCLE-1 of bit DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
  - PARITY: perr = (XOR of data bits XOR parity sample), compared against 1 for odd parity and 0 for even parity. At cnt = CYCLE-1 -> STOP.
  - STOP: ferr set if any checked stop sample is 0. For STOP_BITS = 2, the first stop bit runs a full CYCLE and the second is sampled. The frame completes at resolution of the last stop sample (mid-bit, for resync margin): push, then -> IDLE.
- Break: brk = 1 when all data bits, the parity bit (if present) and the first stop bit are 0. brk implies ferr = 1.
- FIFO entry = {brk, ferr, perr, data}; it is written on the push cycle.
- FIFO rules:
  - Push when not full: the entry is stored.
  - Push when full without a simultaneous pop: entry discarded; rx_overrun <= 1.
  - Push and pop in the same cycle when full: both occur; no overrun; count unchanged.
  - Pop when empty: ignored; pointers and count unchanged.
  - Pointers wrap modulo 2**FIFO_AW. rx_count is registered and updated on the same edge as the pointers.
- Output timing:
  - rx_data_ready = (rx_count != 0). It rises on the edge ending the push cycle.
  - rx_data and the head flags are valid whenever rx_data_ready = 1.
  - After a pop, the next entry (if any) is presented on the following cycle.
- err_clear and a new overrun in the same cycle: set wins; rx_overrun stays 1.
- Reset mid-frame: the frame is abandoned and the FIFO is emptied immediately.
- Break line held low after a break frame: no new start until a high-to-low edge is seen again.

Test Plan:
- CYCLE = 16 (CLK_FRQ 1_600_000, BAUD_RATE 100_000), 8N1; send 0xA5 -> push at mid-stop; rx_data_ready = 1, rx_data = 0xA5, perr = ferr = brk = 0, rx_count = 1; rx_pop -> rx_count = 0, rx_data_ready = 0.
- PARITY = 2, DATA_BITS = 7; send 0x41 with correct parity bit 0 -> perr = 0; resend 0x41 with parity bit 1 -> perr = 1, data = 0x41.
- STOP_BITS = 2; send 0x3C with the second stop bit driven 0 -> ferr = 1, brk = 0; hold line low for 12 bit times -> one entry, data = 0x00, ferr = 1, brk = 1; no further entries until the line goes high and then low again.
- 4-clock low glitch on rx_in while idle -> false start rejected; no push; rx_busy high no longer than CYCLE/2+2 clocks.
- FIFO_AW = 2; send 5 characters 0x01..0x05 with no pops -> rx_count = 4, rx_overrun = 1, head = 0x01; pops return 0x01..0x04; err_clear -> rx_overrun = 0.
- Full FIFO, pop asserted on the push cycle of a 5th character -> no overrun, rx_count stays 4; assert reset_n low mid-frame -> all outputs 0; next clean frame 0x5A is received correctly.
